multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer
// driving datapath enables, plus a wrapping retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction at PC, latch IR and PC+4 on ack
// DECODE | classify opcode; JUMP completes here
// EXEC   | ALU operation / address calc / branch resolve
// MEM    | data memory access for LOAD/STORE, holds until ack
// WB     | register file writeback
// HALT   | stopped until reset
module multicycle_control #(
  parameter int OP_SIZE     = 6,
  parameter int ALU_OP_SIZE = 4,
  parameter int COUNT_SIZE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_SIZE-1:0]     opcode,
  input  logic                   cond_true,
  input  logic                   mem_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   addr_src,
  output logic                   ir_write,
  output logic                   mdr_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   alu_src_b,
  output logic [ALU_OP_SIZE-1:0] alu_op,
  output logic                   reg_write,
  output logic [1:0]             wb_src,
  output logic                   halted,
  output logic                   illegal,
  output logic [COUNT_SIZE-1:0]  retired
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [3:0] CL_RALU   = 4'd0;
  localparam logic [3:0] CL_IALU   = 4'd1;
  localparam logic [3:0] CL_LOAD   = 4'd2;
  localparam logic [3:0] CL_STORE  = 4'd3;
  localparam logic [3:0] CL_BRANCH = 4'd4;
  localparam logic [3:0] CL_JUMP   = 4'd5;
  localparam logic [3:0] CL_LOADI  = 4'd6;
  localparam logic [3:0] CL_HALT   = 4'd7;
  localparam logic [3:0] CL_ILLEGAL = 4'd8;

  logic [2:0] state;
  logic [2:0] nextState;
  logic [3:0] opClass;
  logic [5:0] op6;
  logic       retire;

  assign op6 = opcode[5:0];

  always_comb begin
    opClass = CL_ILLEGAL;
    if (op6[5:4] == 2'b00)        opClass = CL_RALU;
    else if (op6[5:4] == 2'b01)   opClass = CL_IALU;
    else if (op6[5:2] == 4'b1010) opClass = CL_LOAD;
    else if (op6[5:2] == 4'b1011) opClass = CL_STORE;
    else if (op6[5:3] == 3'b100)  opClass = CL_BRANCH;
    else if (op6 == 6'b110000)    opClass = CL_JUMP;
    else if (op6 == 6'b111111)    opClass = CL_LOADI;
    else if (op6 == 6'b111110)    opClass = CL_HALT;
  end

  always_comb begin
    nextState = state;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = '0;
    reg_write = 1'b0;
    wb_src    = 2'b00;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        case (opClass)
          CL_JUMP: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            retire    = 1'b1;
            nextState = FETCH;
          end
          CL_LOADI:   nextState = WB;
          CL_HALT:    nextState = HALT;
          CL_ILLEGAL: begin
            illegal   = 1'b1;
            nextState = FETCH;
          end
          default:    nextState = EXEC;
        endcase
      end
      EXEC: begin
        case (opClass)
          CL_RALU: begin
            alu_op    = ALU_OP_SIZE'(op6[3:0]);
            nextState = WB;
          end
          CL_IALU: begin
            alu_src_b = 1'b1;
            alu_op    = ALU_OP_SIZE'(op6[3:0]);
            nextState = WB;
          end
          CL_LOAD, CL_STORE: begin
            alu_src_b = 1'b1;
            nextState = MEM;
          end
          CL_BRANCH: begin
            alu_op = ALU_OP_SIZE'(op6[3:0]);
            if (cond_true) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            retire    = 1'b1;
            nextState = FETCH;
          end
          default: nextState = FETCH;
        endcase
      end
      MEM: begin
        mem_req   = 1'b1;
        addr_src  = 1'b1;
        alu_src_b = 1'b1;
        mem_we    = (opClass == CL_STORE);
        if (mem_ack) begin
          if (opClass == CL_STORE) begin
            retire    = 1'b1;
            nextState = FETCH;
          end else begin
            mdr_write = 1'b1;
            nextState = WB;
          end
        end
      end
      WB: begin
        reg_write = 1'b1;
        if (opClass == CL_LOAD)       wb_src = 2'b01;
        else if (opClass == CL_LOADI) wb_src = 2'b10;
        retire    = 1'b1;
        nextState = FETCH;
      end
      HALT:    halted = 1'b1;
      default: nextState = FETCH;
    endcase

    // Reset cycle silences every enable so no write can commit on the reset edge.
    if (reset) begin
      retire    = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_src  = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'b00;
      alu_src_b = 1'b0;
      alu_op    = '0;
      reg_write = 1'b0;
      wb_src    = 2'b00;
      halted    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= nextState;
      if (retire) retired <= retired + {{(COUNT_SIZE-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-route reference model,
// directed scenarios with literal expectations, then randomized instruction streams.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        cond_true;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_src, ir_write, mdr_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_src;
  logic        halted, illegal;
  logic [15:0] retired;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cond_true(cond_true), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
    .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_src(wb_src), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       memReq, memWe, addrSrc, irWrite, mdrWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcB;
    logic [3:0] aluOp;
    logic       regWrite;
    logic [1:0] wbSrc;
    logic       halted, illegal;
  } outs_t;

  localparam int RALU = 0, IALU = 1, LOAD = 2, STORE = 3, BRANCH = 4,
                 JUMP = 5, LOADI = 6, HALTC = 7, ILL = 8;

  int tests = 0;
  int failures = 0;
  int cycNum = 0;

  // Model: each instruction class walks a fixed route of phases; F and M wait for ack.
  int          pos = 0;
  int          hCount = 0;
  logic [15:0] mRetired = '0;
  outs_t       sOut;

  function automatic int clsOf(input logic [5:0] op);
    if (op[5:4] == 2'b00) return RALU;
    if (op[5:4] == 2'b01) return IALU;
    if (op[5:2] == 4'b1010) return LOAD;
    if (op[5:2] == 4'b1011) return STORE;
    if (op[5:3] == 3'b100) return BRANCH;
    if (op == 6'b110000) return JUMP;
    if (op == 6'b111111) return LOADI;
    if (op == 6'b111110) return HALTC;
    return ILL;
  endfunction

  function automatic string routeOf(input int c);
    case (c)
      RALU, IALU: return "FDEW";
      LOAD:       return "FDEMW";
      STORE:      return "FDEM";
      BRANCH:     return "FDE";
      LOADI:      return "FDW";
      HALTC:      return "FDH";
      default:    return "FD";
    endcase
  endfunction

  function automatic byte phaseOf(input logic [5:0] op);
    string rt;
    rt = routeOf(clsOf(op));
    return rt[pos];
  endfunction

  function automatic outs_t expOut(input logic [5:0] op, input logic ack,
                                   input logic cond, input logic rst);
    outs_t o;
    int    c;
    byte   ph;
    o  = '0;
    c  = clsOf(op);
    ph = phaseOf(op);
    if (rst) return o;
    if (ph == "F") begin
      o.memReq = 1'b1;
      if (ack) begin o.irWrite = 1'b1; o.pcWrite = 1'b1; end
    end else if (ph == "D") begin
      if (c == JUMP) begin o.pcWrite = 1'b1; o.pcSrc = 2'd2; end
      if (c == ILL) o.illegal = 1'b1;
    end else if (ph == "E") begin
      o.aluSrcB = (c == IALU || c == LOAD || c == STORE);
      o.aluOp   = (c == LOAD || c == STORE) ? 4'd0 : op[3:0];
      if (c == BRANCH && cond) begin o.pcWrite = 1'b1; o.pcSrc = 2'd1; end
    end else if (ph == "M") begin
      o.memReq  = 1'b1;
      o.addrSrc = 1'b1;
      o.aluSrcB = 1'b1;
      o.memWe   = (c == STORE);
      o.mdrWrite = ack && (c == LOAD);
    end else if (ph == "W") begin
      o.regWrite = 1'b1;
      o.wbSrc    = (c == LOAD) ? 2'd1 : (c == LOADI) ? 2'd2 : 2'd0;
    end else if (ph == "H") begin
      o.halted = 1'b1;
    end
    return o;
  endfunction

  task automatic advance(input logic rst, input logic [5:0] op, input logic ack);
    string rt;
    byte   ph;
    rt = routeOf(clsOf(op));
    ph = rt[pos];
    if (rst) begin
      pos = 0; mRetired = '0; hCount = 0;
    end else if (ph == "H") begin
      hCount++;
    end else if ((ph == "F" || ph == "M") && !ack) begin
      pos = pos;
    end else begin
      pos++;
      if (pos == rt.len()) begin
        pos = 0;
        if (clsOf(op) != ILL) mRetired = mRetired + 16'd1;
      end
    end
  endtask

  function automatic void chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Called just after a rising edge; applies inputs, checks at the falling edge, steps the model.
  task automatic cycle(input logic r, input logic [5:0] op, input logic ack, input logic cond);
    outs_t e;
    reset = r; opcode = op; mem_ack = ack; cond_true = cond;
    @(negedge clk);
    sOut = {mem_req, mem_we, addr_src, ir_write, mdr_write, pc_write, pc_src,
            alu_src_b, alu_op, reg_write, wb_src, halted, illegal};
    e = expOut(op, ack, cond, r);
    tests++;
    if (sOut !== e) begin
      failures++;
      $display("FAIL outputs cyc %0d op %b: got %h expected %h", cycNum, op, sOut, e);
    end
    tests++;
    if (retired !== mRetired) begin
      failures++;
      $display("FAIL retired cyc %0d: got %0d expected %0d", cycNum, retired, mRetired);
    end
    @(posedge clk);
    advance(r, op, ack);
    cycNum++;
    #1;
  endtask

  initial begin
    logic [5:0] curOp;
    logic       r;
    reset = 1'b1; opcode = '0; mem_ack = 1'b0; cond_true = 1'b0;
    @(posedge clk);
    #1;

    cycle(1'b1, 6'b000000, 1'b1, 1'b0);
    chk("reset outputs", int'(sOut), 0);
    chk("reset retired", int'(retired), 0);

    // RALU, zero-wait: 4 cycles
    cycle(1'b0, 6'b000000, 1'b1, 1'b0);
    chk("ralu fetch memReq", sOut.memReq, 1);
    cycle(1'b0, 6'b000000, 1'b1, 1'b0);
    cycle(1'b0, 6'b000000, 1'b1, 1'b0);
    chk("ralu exec aluOp", sOut.aluOp, 0);
    chk("ralu exec aluSrcB", sOut.aluSrcB, 0);
    cycle(1'b0, 6'b000000, 1'b1, 1'b0);
    chk("ralu wb regWrite", sOut.regWrite, 1);
    chk("ralu wb wbSrc", sOut.wbSrc, 0);
    chk("ralu retired", int'(retired), 1);

    // LOAD with 3 memory wait cycles: 8 cycles
    cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'b101000, 1'b0, 1'b0);
      chk("load mem wait req/we/addr", {sOut.memReq, sOut.memWe, sOut.addrSrc}, 3'b101);
    end
    cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    chk("load mem ack mdrWrite", sOut.mdrWrite, 1);
    chk("load mem ack memReq", sOut.memReq, 1);
    cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    chk("load wb wbSrc", sOut.wbSrc, 1);
    chk("load retired", int'(retired), 2);

    // BRANCH taken then not taken
    for (int t = 1; t >= 0; t--) begin
      cycle(1'b0, 6'b100110, 1'b1, t[0]);
      cycle(1'b0, 6'b100110, 1'b1, t[0]);
      cycle(1'b0, 6'b100110, 1'b1, t[0]);
      chk("branch pcWrite", sOut.pcWrite, t);
      chk("branch pcSrc", sOut.pcSrc, t);
      chk("branch aluOp", sOut.aluOp, 6);
    end
    chk("branch retired", int'(retired), 4);

    // JUMP 2 cycles, STORE 4 cycles
    cycle(1'b0, 6'b110000, 1'b1, 1'b0);
    cycle(1'b0, 6'b110000, 1'b1, 1'b0);
    chk("jump pcWrite/pcSrc", {sOut.pcWrite, sOut.pcSrc}, 3'b110);
    chk("jump retired", int'(retired), 5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'b101100, 1'b1, 1'b0);
    chk("store memWe", sOut.memWe, 1);
    chk("store retired", int'(retired), 6);

    // Illegal opcode: one-cycle pulse, no retire
    cycle(1'b0, 6'b111000, 1'b1, 1'b0);
    chk("illegal fetch pulse", sOut.illegal, 0);
    cycle(1'b0, 6'b111000, 1'b1, 1'b0);
    chk("illegal pulse", sOut.illegal, 1);
    cycle(1'b0, 6'b111000, 1'b0, 1'b0);
    chk("illegal pulse end", sOut.illegal, 0);
    chk("illegal retired", int'(retired), 6);

    // HALT holds until reset
    cycle(1'b0, 6'b111110, 1'b1, 1'b0);
    cycle(1'b0, 6'b111110, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'b111110, 1'b1, 1'b0);
    chk("halt halted", sOut.halted, 1);
    chk("halt memReq", sOut.memReq, 0);
    cycle(1'b1, 6'b111110, 1'b1, 1'b0);
    cycle(1'b0, 6'b101000, 1'b0, 1'b0);
    chk("post-halt memReq", sOut.memReq, 1);
    chk("post-halt halted", sOut.halted, 0);

    // Reset during MEM with ack and retired=5 aborts the LOAD
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'b110000, 1'b1, 1'b0);
    chk("pre-abort retired", int'(retired), 5);
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'b101000, 1'b1, 1'b0);
    cycle(1'b1, 6'b101000, 1'b1, 1'b0);
    chk("abort mdrWrite", sOut.mdrWrite, 0);
    chk("abort regWrite", sOut.regWrite, 0);
    chk("abort retired", int'(retired), 0);
    cycle(1'b0, 6'b101000, 1'b0, 1'b0);
    chk("abort fetch memReq", sOut.memReq, 1);
    chk("abort fetch mdrWrite", sOut.mdrWrite, 0);

    // Randomized instruction stream
    curOp = 6'b000000;
    for (int n = 0; n < 4000; n++) begin
      if (pos == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0: curOp = 6'b110000;
            1: curOp = 6'b111111;
            2: curOp = 6'b111110;
            3: curOp = 6'b111000;
            default: curOp = 6'b111101;
          endcase
        end else begin
          curOp = 6'($urandom_range(0, 63));
        end
      end
      r = (phaseOf(curOp) == "H" && hCount > 4) || ($urandom_range(0, 79) == 0);
      cycle(r, curOp, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
